// File: rtl/dma_priority_resolver.sv
// Channel priority resolver and HRQ/HLDA bus-request handshake for the 4-channel DMA controller.
// Merges hardware and software requests, picks a winner (fixed or rotating) and holds the grant until release.
module dma_priority_resolver #(
    parameter int NUM_CH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [7:0]        commandReg,
    input  logic [7:0]        requestReg,
    input  logic [7:0]        maskReg,
    input  logic              HLDA,
    input  logic              svcDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [1:0]        grantChan,
    output logic [NUM_CH-1:0] swReqClr
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT} stateT;

    stateT             state, stateNext;
    logic [NUM_CH-1:0] dreqQ;
    logic [NUM_CH-1:0] pend, pendEff;
    logic [NUM_CH-1:0] ack, ackNext;
    logic [NUM_CH-1:0] swReqClrNext;
    logic [1:0]        prio, prioNext;
    logic [1:0]        grantChanNext;
    logic              hrqNext, grantValidNext;
    logic              swAtGrant, swAtGrantNext;
    logic [1:0]        winner, searchBase, idx;
    logic              found;
    logic              unusedBits;

    assign unusedBits = ^{commandReg[5], commandReg[3], commandReg[1:0],
                          requestReg[7:NUM_CH], maskReg[7:NUM_CH]};

    function automatic logic [NUM_CH-1:0] oneHot(input logic [1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    // Software requests bypass the mask; disable only gates new requests.
    assign pend    = (dreqQ & ~maskReg[NUM_CH-1:0]) | requestReg[NUM_CH-1:0];
    assign pendEff = commandReg[2] ? '0 : pend;

    always_comb begin
        winner     = '0;
        found      = 1'b0;
        idx        = '0;
        searchBase = commandReg[4] ? prio : 2'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = searchBase + k[1:0];
            if (!found && pendEff[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext      = state;
        hrqNext        = HRQ;
        grantValidNext = grantValid;
        grantChanNext  = grantChan;
        ackNext        = ack;
        swReqClrNext   = '0;
        prioNext       = prio;
        swAtGrantNext  = swAtGrant;
        unique case (state)
            IDLE: begin
                if (|pendEff) begin
                    stateNext = REQ;
                    hrqNext   = 1'b1;
                end
            end
            REQ: begin
                if (!(|pendEff)) begin
                    stateNext = IDLE;
                    hrqNext   = 1'b0;
                end else if (HLDA) begin
                    stateNext      = GRANT;
                    grantValidNext = 1'b1;
                    grantChanNext  = winner;
                    ackNext        = oneHot(winner);
                    swAtGrantNext  = requestReg[winner];
                end
            end
            GRANT: begin
                // svcDone wins over a simultaneous HLDA drop
                if (svcDone || !HLDA) begin
                    stateNext      = IDLE;
                    hrqNext        = 1'b0;
                    grantValidNext = 1'b0;
                    ackNext        = '0;
                    if (svcDone) begin
                        if (swAtGrant) swReqClrNext = ack;
                        if (commandReg[4]) prioNext = grantChan + 2'd1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            dreqQ      <= '0;
            HRQ        <= 1'b0;
            grantValid <= 1'b0;
            grantChan  <= '0;
            ack        <= '0;
            swReqClr   <= '0;
            prio       <= '0;
            swAtGrant  <= 1'b0;
        end else begin
            state      <= stateNext;
            dreqQ      <= DREQ ^ {NUM_CH{commandReg[6]}};
            HRQ        <= hrqNext;
            grantValid <= grantValidNext;
            grantChan  <= grantChanNext;
            ack        <= ackNext;
            swReqClr   <= swReqClrNext;
            prio       <= prioNext;
            swAtGrant  <= swAtGrantNext;
        end
    end

    assign DACK = ack ^ {NUM_CH{~commandReg[7]}};

endmodule
